// File: rtl/booth_mul.sv
// Radix-2 Booth signed 32x32 multiplier: one iteration per clock, 32 iterations per product.
// state | meaning
// IDLE  | waiting for start_i; operands are captured on the accepting edge
// RUN   | one add/shift step per edge; cnt_q counts remaining steps
// FIN   | product valid in p_o; done_o high for this single cycle
module booth_mul (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        start_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [63:0] p_o
);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t      state_q, state_d;
  logic [31:0] m_q, m_d;
  logic [31:0] q_q, q_d;
  logic [32:0] ac_q, ac_d;
  logic        qm1_q, qm1_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [63:0] p_q, p_d;

  logic [32:0] m_ext;
  logic [32:0] addend;
  logic [32:0] sum;
  logic [65:0] shifted;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      m_q     <= '0;
      q_q     <= '0;
      ac_q    <= '0;
      qm1_q   <= 1'b0;
      cnt_q   <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      q_q     <= q_d;
      ac_q    <= ac_d;
      qm1_q   <= qm1_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
    end
  end

  // 33-bit accumulator keeps -M representable when M is the most negative value
  always_comb begin
    m_ext = {m_q[31], m_q};
    case ({q_q[0], qm1_q})
      2'b01:   addend = m_ext;
      2'b10:   addend = ~m_ext + 33'd1;
      default: addend = '0;
    endcase
    sum     = ac_q + addend;
    shifted = {sum[32], sum, q_q};
  end

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    q_d     = q_q;
    ac_d    = ac_q;
    qm1_d   = qm1_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          m_d     = a_i;
          q_d     = b_i;
          ac_d    = '0;
          qm1_d   = 1'b0;
          cnt_d   = 6'd32;
          state_d = RUN;
        end
      end
      RUN: begin
        ac_d  = shifted[65:33];
        q_d   = shifted[32:1];
        qm1_d = shifted[0];
        cnt_d = cnt_q - 6'd1;
        if (cnt_q == 6'd1) begin
          p_d     = shifted[64:1];
          state_d = FIN;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy_o = (state_q == RUN);
  assign done_o = (state_q == FIN);
  assign p_o    = p_q;

endmodule

// File: tb/tb_booth_mul.sv
// Bench for booth_mul: cycle-level reference model built on native signed multiplication,
// compared against the DUT on every clock, plus directed literal cases.
module tb_booth_mul;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy;
  logic        done;
  logic [63:0] p;

  booth_mul dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .start_i (start),
    .a_i     (a),
    .b_i     (b),
    .busy_o  (busy),
    .done_o  (done),
    .p_o     (p)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int dones = 0;
  int cyc = 0;
  int last_done = -1;
  bit soak = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Reference model: operation accepted in idle, product after 32 edges, one FIN cycle.
  typedef enum {M_IDLE, M_RUN, M_FIN} mst_t;
  mst_t        ms = M_IDLE;
  int          k = 0;
  longint      sa, sb;
  logic [63:0] pend = '0;
  logic [63:0] p_e = '0;
  logic        busy_e = 1'b0;
  logic        done_e = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ms = M_IDLE; p_e = '0; busy_e = 1'b0; done_e = 1'b0; k = 0;
    end else begin
      cyc++;
      case (ms)
        M_IDLE: if (start) begin
          sa = longint'($signed(a));
          sb = longint'($signed(b));
          pend = sa * sb;
          k = 0; busy_e = 1'b1; ms = M_RUN;
        end
        M_RUN: begin
          k++;
          if (k == 32) begin
            p_e = pend; done_e = 1'b1; busy_e = 1'b0; ms = M_FIN;
          end
        end
        M_FIN: begin
          done_e = 1'b0; ms = M_IDLE;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy", {63'd0, busy}, {63'd0, busy_e});
      chk("done", {63'd0, done}, {63'd0, done_e});
      chk("p", p, p_e);
      if (done) begin
        dones++;
        if (soak && last_done >= 0) chk("period", 64'(cyc - last_done), 64'd34);
        last_done = cyc;
      end
    end
  end

  task automatic run_op(input logic [31:0] av, input logic [31:0] bv,
                        input logic [63:0] exp, input string nm, input bit inject);
    int lat, nb, d0;
    d0 = dones;
    @(negedge clk);
    a = av; b = bv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0; nb = 0;
    while (!done && lat < 40) begin
      if (busy) nb++;
      if (inject && lat == 5) begin start = 1'b1; a = 32'd100; b = 32'd100; end
      if (inject && lat == 6) start = 1'b0;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    chk({nm, "_latency"}, 64'(lat), 64'd32);
    chk({nm, "_busycycles"}, 64'(nb), 64'd32);
    chk({nm, "_p"}, p, exp);
    chk({nm, "_model"}, p_e, exp);
    repeat (4) @(negedge clk);
    chk({nm, "_donecount"}, 64'(dones - d0), 64'd1);
  endtask

  initial begin
    int d0;
    int n;
    repeat (3) @(negedge clk);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_p", p, 64'd0);
    rst_n = 1'b1;

    run_op(32'd2, 32'd3, 64'h0000_0000_0000_0006, "two_x_three", 1'b0);
    run_op(32'd7, 32'hFFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFDD, "seven_x_m5", 1'b0);
    run_op(32'h8000_001E, 32'd1, 64'hFFFF_FFFF_8000_001E, "neg_x_one", 1'b0);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, "min_x_m1", 1'b0);
    run_op(32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, "min_x_min", 1'b0);
    run_op(32'd3, 32'd5, 64'd15, "start_ignored", 1'b1);

    // reset in the middle of a run
    @(negedge clk);
    a = 32'd5; b = 32'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    chk("midrst_done", {63'd0, done}, 64'd0);
    chk("midrst_p", p, 64'd0);
    d0 = dones;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("midrst_nodone", 64'(dones - d0), 64'd0);
    chk("midrst_p_after", p, 64'd0);

    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd1, "after_reset", 1'b0);

    // back-to-back soak with operands changing every cycle
    n = 1500;
    d0 = dones;
    soak = 1'b1;
    last_done = -1;
    @(negedge clk);
    start = 1'b1; a = $urandom; b = $urandom;
    repeat (n * 34 - 1) begin
      @(negedge clk);
      a = $urandom; b = $urandom;
    end
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);
    soak = 1'b0;
    chk("soak_donecount", 64'(dones - d0), 64'(n));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
